// File: rtl/fp_pkg.sv
// Shared widths, IEEE-754 single constants and converter state encoding
// for the float-to-integer egress path.
package fp_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;

    localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        DONE  = 2'd3
    } cvt_state_t;

endpackage

// File: rtl/fp_to_int_if.sv
// Operand/result handshake bundle for fp_to_int.
// A transfer happens on a rising edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that edge.
interface fp_to_int_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        invalid;
    logic        inexact;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, c, invalid, inexact
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, c, invalid, inexact
    );

endinterface

// File: rtl/fp_unpack.sv
// Combinational split of a single-precision operand into sign, mantissa,
// input class and the alignment shift needed to reach integer weight.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       a,
    output logic              s,
    output logic [MANT_W:0]   m,
    output logic              isZero,
    output logic              isNan,
    output logic              isInf,
    output logic              isOvf,
    output logic              isSmall,
    output logic [4:0]        shiftCnt,
    output logic              shiftRight
);

    logic [EXP_W-1:0]  expField;
    logic [MANT_W-1:0] frac;
    logic [EXP_W-1:0]  rightAmt;
    logic [EXP_W-1:0]  leftAmt;

    // Exponent 150 (e = 23) puts the mantissa LSB exactly at weight 1.
    localparam logic [EXP_W-1:0] ALIGN_EXP = 8'(FP_BIAS + MANT_W);
    localparam logic [EXP_W-1:0] OVF_EXP   = 8'(FP_BIAS + 31);

    assign s        = a[31];
    assign expField = a[30:23];
    assign frac     = a[22:0];
    assign m        = {1'b1, frac};

    assign isZero   = (expField == 8'd0);
    assign isNan    = (expField == 8'hFF) && (frac != '0);
    assign isInf    = (expField == 8'hFF) && (frac == '0);
    assign isOvf    = (expField != 8'hFF) && (expField >= OVF_EXP);
    assign isSmall  = (expField != 8'd0) && (expField < 8'(FP_BIAS));

    assign rightAmt   = ALIGN_EXP - expField;
    assign leftAmt    = expField - ALIGN_EXP;
    assign shiftRight = (expField < ALIGN_EXP);
    assign shiftCnt   = shiftRight ? rightAmt[4:0] : leftAmt[4:0];

endmodule

// File: rtl/fp_to_int.sv
// Float to signed 32-bit integer, round toward zero, using a one-bit-per-cycle
// aligner; special classes bypass the shifter and complete on the accept edge.
module fp_to_int
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fp_to_int_if.slave      bus,
    output cvt_state_t      dbgState
);

    cvt_state_t  state, stateNext;

    logic              uS;
    logic [MANT_W:0]   uM;
    logic              isZero, isNan, isInf, isOvf, isSmall;
    logic [4:0]        shiftCnt;
    logic              shiftRight;

    logic              isSpecial;
    logic [31:0]       specC;
    logic              specInv;
    logic              specInx;

    logic              signReg;
    logic [31:0]       mag;
    logic [4:0]        cnt;
    logic              dirRight;
    logic              sticky;
    logic [31:0]       cReg;
    logic              invalidReg;
    logic              inexactReg;

    fp_unpack u_unpack (
        .a          (bus.a),
        .s          (uS),
        .m          (uM),
        .isZero     (isZero),
        .isNan      (isNan),
        .isInf      (isInf),
        .isOvf      (isOvf),
        .isSmall    (isSmall),
        .shiftCnt   (shiftCnt),
        .shiftRight (shiftRight)
    );

    assign isSpecial = isZero | isNan | isInf | isOvf | isSmall;

    // -2^31 is the one out-of-range magnitude that is still representable.
    always_comb begin
        specC   = 32'd0;
        specInv = 1'b0;
        specInx = 1'b0;
        if (isNan) begin
            specC   = INT_MAX;
            specInv = 1'b1;
        end else if (isInf || isOvf) begin
            specC   = uS ? INT_MIN : INT_MAX;
            specInv = (bus.a != 32'hCF000000);
        end else if (isZero) begin
            specInx = |bus.a[22:0];
        end else if (isSmall) begin
            specInx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (isSpecial)           stateNext = DONE;
                    else if (shiftCnt != '0) stateNext = SHIFT;
                    else                     stateNext = FIX;
                end
            end
            SHIFT:   if (cnt == 5'd1) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signReg    <= 1'b0;
            mag        <= '0;
            cnt        <= '0;
            dirRight   <= 1'b0;
            sticky     <= 1'b0;
            cReg       <= '0;
            invalidReg <= 1'b0;
            inexactReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        signReg  <= uS;
                        mag      <= {8'd0, uM};
                        cnt      <= shiftCnt;
                        dirRight <= shiftRight;
                        sticky   <= 1'b0;
                        if (isSpecial) begin
                            cReg       <= specC;
                            invalidReg <= specInv;
                            inexactReg <= specInx;
                        end
                    end
                end
                SHIFT: begin
                    if (dirRight) begin
                        mag    <= mag >> 1;
                        sticky <= sticky | mag[0];
                    end else begin
                        mag    <= mag << 1;
                    end
                    cnt <= cnt - 5'd1;
                end
                FIX: begin
                    cReg       <= signReg ? (32'd0 - mag) : mag;
                    invalidReg <= 1'b0;
                    inexactReg <= sticky;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.c         = cReg;
    assign bus.invalid   = invalidReg;
    assign bus.inexact   = inexactReg;
    assign dbgState      = state;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed-vector bench for fp_to_int: latency, saturation, small inputs,
// backpressure hold and mid-conversion reset.
module tb_fp_to_int;
    import fp_pkg::*;

    logic       clk;
    logic       rst;
    cvt_state_t dbgState;

    fp_to_int_if bus ();

    fp_to_int dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: waits (bounded) for in_ready, presents a for one accept edge
    task automatic send(input logic [31:0] val);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.a        = val;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // waits for out_valid and checks latency, result and flags
    task automatic collect(input string tag, input logic expInv, input logic expInx,
                           input int expLat);
        int lat;
        logic [31:0] expC;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(expLat));
        expC = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check_eq({tag, "_c"}, bus.c, expC);
        check_eq({tag, "_invalid"}, 32'(bus.invalid), 32'(expInv));
        check_eq({tag, "_inexact"}, 32'(bus.inexact), 32'(expInx));
    endtask

    task automatic run_vec(input string tag, input logic [31:0] val, input logic [31:0] expC,
                           input logic expInv, input logic expInx, input int expLat);
        exp_q.push_back(expC);
        send(val);
        collect(tag, expInv, expInx, expLat);
        @(posedge clk); #1;
        check_eq({tag, "_ovalid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] holdC;
        logic        holdInv, holdInx;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_c",        bus.c,                 32'd0);
        check_eq("rst_ovalid",   32'(bus.out_valid),    32'd0);
        check_eq("rst_iready",   32'(bus.in_ready),     32'd0);
        check_eq("rst_invalid",  32'(bus.invalid),      32'd0);
        check_eq("rst_inexact",  32'(bus.inexact),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_iready", 32'(bus.in_ready), 32'd1);

        // normal path
        run_vec("one",      32'h3F800000, 32'h00000001, 1'b0, 1'b0, 24);
        run_vec("neg_pi",   32'hC0490FDB, 32'hFFFFFFFD, 1'b0, 1'b1, 23);
        run_vec("left7",    32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 8);
        run_vec("cnt0_pos", 32'h4B000000, 32'h00800000, 1'b0, 1'b0, 1);
        run_vec("cnt0_neg", 32'hCB000000, 32'hFF800000, 1'b0, 1'b0, 1);
        run_vec("ten",      32'h41200000, 32'h0000000A, 1'b0, 1'b0, 21);

        // range limits and specials
        run_vec("int_min",  32'hCF000000, 32'h80000000, 1'b0, 1'b0, 0);
        run_vec("pos_ovf",  32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 0);
        run_vec("neg_ovf",  32'hCF000001, 32'h80000000, 1'b1, 1'b0, 0);
        run_vec("neg_inf",  32'hFF800000, 32'h80000000, 1'b1, 1'b0, 0);
        run_vec("pos_inf",  32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 0);
        run_vec("nan",      32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 0);
        run_vec("half",     32'h3F000000, 32'h00000000, 1'b0, 1'b1, 0);
        run_vec("neg_zero", 32'h80000000, 32'h00000000, 1'b0, 1'b0, 0);
        run_vec("denorm",   32'h00000001, 32'h00000000, 1'b0, 1'b1, 0);

        // backpressure: result held, new operands ignored
        bus.out_ready = 1'b0;
        exp_q.push_back(32'h0000000A);
        send(32'h41200000);
        collect("bp", 1'b0, 1'b0, 21);
        holdC   = bus.c;
        holdInv = bus.invalid;
        holdInx = bus.inexact;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a        = $urandom_range(32'h3F800000, 32'h4EFFFFFF);
            @(posedge clk); #1;
            check_eq("bp_c",       bus.c,                32'h0000000A);
            check_eq("bp_ovalid",  32'(bus.out_valid),   32'd1);
            check_eq("bp_iready",  32'(bus.in_ready),    32'd0);
            check_eq("bp_flags",   {30'd0, bus.invalid, bus.inexact}, {30'd0, holdInv, holdInx});
        end
        check_eq("bp_c_hold", bus.c, holdC);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_ovalid", 32'(bus.out_valid), 32'd0);
        check_eq("bp_release_iready", 32'(bus.in_ready),  32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_no_extra", 32'(bus.out_valid), 32'd0);

        // reset in the middle of a conversion
        send(32'h3F800000);
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_state", 32'(dbgState), 32'(SHIFT));
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ovalid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_c",      bus.c,              32'd0);
        check_eq("mid_rst_iready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_post_iready", 32'(bus.in_ready), 32'd1);
        run_vec("ten_after_rst", 32'h41200000, 32'h0000000A, 1'b0, 1'b0, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Multi-cycle converter from IEEE-754 single-precision to signed 32-bit two's-complement integer, rounding toward zero. It unpacks sign, exponent and mantissa, aligns the mantissa with an iterative one-bit-per-cycle shifter, then applies the sign. It sits behind the FP add/sub datapath as the float-to-integer egress path, with valid/ready handshakes on both sides.

## Interface
- None: all widths are fixed by `fp_pkg`.

- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand `a` is valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- a  in  32  IEEE-754 single operand.
- out_valid  out  1  result `c` and flags are valid.
- out_ready  in  1  consumer accepts the result.
- c  out  32  signed integer result.
- invalid  out  1  NaN, Inf or out-of-range input; `c` saturated.
- inexact  out  1  nonzero fraction bits were discarded.

## Operation
- Unpack: `s = a[31]`, `E = a[30:23]`, `m = {1, a[22:0]}`, `e = E − 127`.
- Classes, evaluated at accept time:
  - E = 0 (zero or denormal): `c = 0`; `inexact = |a[22:0]`; `-0` gives 0.
  - E = 255, NaN: `c = 0x7FFFFFFF`, `invalid = 1`.
  - E = 255, ±Inf: `c = 0x7FFFFFFF` for +Inf, `0x80000000` for −Inf; `invalid = 1`.
  - e ≥ 31: saturate as for ±Inf with `invalid = 1`. Exception: `a = 0xCF000000` gives `c = 0x80000000` with `invalid = 0`.
  - e < 0: `c = 0`, `inexact = 1`.
  - 0 ≤ e ≤ 30: normal path. Set `mag = {8'b0, m}`. Shift direction is right when e < 23, left when e > 23. Shift count is `cnt = |e − 23|` (0..23, 5-bit counter).
- States: IDLE, SHIFT, FIX, DONE.
  - IDLE: `in_ready = 1`. On `in_valid`:
    - special class: load the result and flags, go to DONE.
    - normal with cnt > 0: go to SHIFT.
    - normal with cnt = 0: go to FIX.
  - SHIFT: shift `mag` one bit per cycle and decrement `cnt`.
    - On a right shift, OR the bit shifted out into a sticky bit.
    - When `cnt` reaches 1, perform that last shift and go to FIX.
  - FIX: `c = s ? −mag : mag`, `inexact = sticky`, `invalid = 0`; go to DONE.
  - DONE: `out_valid = 1`. When `out_ready` is high, go to IDLE.
- In DONE, `c`, `invalid` and `inexact` are held stable until the handshake completes.
- `in_valid` is ignored outside IDLE. There is exactly one transaction in flight; no overlap.

## Timing
- Reset values: state IDLE; `c = 0`, `invalid = 0`, `inexact = 0`, `out_valid = 0`. `in_ready = 0` while `rst` is high and 1 after release.
- Latency, measured from the accepting edge to the first cycle with `out_valid` high:
  - special class: visible immediately after the accepting edge (0 extra edges).
  - normal path: `cnt + 1` further edges. Range is 1 to 24.
- DONE → IDLE on the `out_valid && out_ready` edge. A new operand is accepted at the earliest on the following edge, so minimum issue interval is 2 cycles.
- `in_ready`, `out_valid`: combinational from the state register only, with no combinational path from inputs.
- Reset asserted mid-operation (any state) aborts immediately: outputs return to reset values and the partial result is discarded.

## Structure
- `fp_pkg` holds the shared definitions:
  - `FP_BIAS = 127`, `EXP_W = 8`, `MANT_W = 23`
  - `INT_MAX = 32'h7FFFFFFF`, `INT_MIN = 32'h80000000`
  - state enum `cvt_state_t` {IDLE, SHIFT, FIX, DONE}
- One combinational sub-module, `fp_unpack`. Inputs: `a`. Outputs: `s`, `m`, class bits (`is_zero`, `is_nan`, `is_inf`, `is_ovf`, `is_small`), shift count, shift direction.
- `fp_to_int` owns the FSM, the shifter, the sticky bit and the negation.

## Test plan
- 1.0 `0x3F800000` → `c = 0x00000001`, `inexact = 0`, `invalid = 0`; `out_valid` 24 edges after accept.
- −3.14159 `0xC0490FDB` → `c = 0xFFFFFFFD`, `inexact = 1`. `0x4EFFFFFF` → `c = 0x7FFFFF80`, `inexact = 0` (left-shift path, 8-edge latency).
- Range limits:
  - `0xCF000000` → `0x80000000`, `invalid = 0`
  - `0x4F000000` → `0x7FFFFFFF`, `invalid = 1`
  - −Inf `0xFF800000` → `0x80000000`, `invalid = 1`
  - NaN `0x7FC00000` → `0x7FFFFFFF`, `invalid = 1`
- Small and zero inputs:
  - 0.5 `0x3F000000` → `0`, `inexact = 1`
  - −0 `0x80000000` → `0`, `inexact = 0`
  - denormal `0x00000001` → `0`, `inexact = 1`
  - Special classes show `out_valid` on the cycle after accept.
- Backpressure: hold `out_ready = 0` for 10 cycles after `out_valid`. `c` and flags stay constant, `in_ready` stays 0, and toggling `in_valid` with new `a` is ignored. Release gives a single handshake, then IDLE.
- Reset mid-conversion: assert `rst` 5 cycles into converting 1.0. `out_valid` drops to 0 and `c` to 0 at once. After release, `in_ready = 1`, and the next operand `0x41200000` (10.0) yields `c = 0x0000000A`.
